// File: rtl/deck_lookup_pkg.sv
// Shared deck constants, card-code layout and the card lookup helper.
// Card code is {valid, suit[1:0], rank[3:0]}; invalid addresses map to 0.
package deck_lookup_pkg;

  localparam int DECK_SIZE      = 52;
  localparam int RANKS_PER_SUIT = 13;

  localparam logic [1:0] SUIT_CLUBS    = 2'd0;
  localparam logic [1:0] SUIT_DIAMONDS = 2'd1;
  localparam logic [1:0] SUIT_HEARTS   = 2'd2;
  localparam logic [1:0] SUIT_SPADES   = 2'd3;

  localparam int VALID_BIT = 6;
  localparam int SUIT_MSB  = 5;
  localparam int SUIT_LSB  = 4;
  localparam int RANK_MSB  = 3;
  localparam int RANK_LSB  = 0;

  typedef struct packed {
    logic       valid;
    logic [1:0] suit;
    logic [3:0] rank;
  } card_t;

  function automatic card_t card_lookup(
    input logic [5:0] a
  );
    card_t      c;
    logic [5:0] base;
    c    = '0;
    base = '0;
    unique case (1'b1)
      (a < 6'd13): begin
        c.suit = SUIT_CLUBS;
        base   = 6'd0;
      end
      (a >= 6'd13 && a < 6'd26): begin
        c.suit = SUIT_DIAMONDS;
        base   = 6'd13;
      end
      (a >= 6'd26 && a < 6'd39): begin
        c.suit = SUIT_HEARTS;
        base   = 6'd26;
      end
      (a >= 6'd39 && a < 6'd52): begin
        c.suit = SUIT_SPADES;
        base   = 6'd39;
      end
      default: begin
        c.suit = 2'd0;
        base   = a;
      end
    endcase
    if (a < 6'd52) begin
      c.valid = 1'b1;
      c.rank  = 4'(a - base + 6'd1);
    end else begin
      c = '0;
    end
    return c;
  endfunction

endpackage

// File: rtl/deck_lookup_points.sv
// Blackjack point value of a card rank.
// Ace counts 1, faces count 10, rank 0 (empty slot) counts 0.
module card_points
  import deck_lookup_pkg::*;
(
  input  logic [3:0] rank,
  output logic [3:0] points
);

  // rank to hard point value
  always_comb begin
    points = 4'd0;
    unique case (1'b1)
      (rank == 4'd0):                 points = 4'd0;
      (rank >= 4'd1 && rank <= 4'd10): points = rank;
      (rank >= 4'd11 && rank <= 4'd13): points = 4'd10;
      default:                        points = 4'd0;
    endcase
  end

endmodule

// File: rtl/deck_lookup.sv
// 52-card deck lookup: combinational card code and points,
// plus a registered copy of both with async active-low clear.
module deck_lookup
  import deck_lookup_pkg::*;
#(
  parameter int DECK_SIZE = deck_lookup_pkg::DECK_SIZE
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] addr,
  output logic [6:0] data_out,
  output logic [3:0] points,
  output logic [6:0] data_q,
  output logic [3:0] points_q
);

  card_t      card;
  logic [6:0] data_d;
  logic [3:0] points_d;
  logic [3:0] rank;

  // table lookup; anything past the deck reads as an empty code
  always_comb begin
    card = '0;
    if (32'(addr) < DECK_SIZE) begin
      card = card_lookup(addr);
    end
    data_d = card;
    rank   = data_d[RANK_MSB:RANK_LSB];
  end

  card_points u_points (
    .rank   (rank),
    .points (points_d)
  );

  assign data_out = data_d;
  assign points   = points_d;

  // output register, cleared while reset is held
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q   <= '0;
      points_q <= '0;
    end else begin
      data_q   <= data_d;
      points_q <= points_d;
    end
  end

endmodule

// File: tb/tb_deck_lookup.sv
// Bench for deck_lookup: directed vectors, full address sweep,
// reset behaviour; registered outputs checked through a queue.
module tb_deck_lookup;

  logic       clk;
  logic       rst_n;
  logic [5:0] addr;
  logic [6:0] data_out;
  logic [3:0] points;
  logic [6:0] data_q;
  logic [3:0] points_q;

  int checks;
  int failures;

  logic [10:0] sb_q[$];

  deck_lookup dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .addr     (addr),
    .data_out (data_out),
    .points   (points),
    .data_q   (data_q),
    .points_q (points_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // reference: {code[6:0], points[3:0]}
  function automatic logic [10:0] ref_card(input int a);
    int s;
    int r;
    int p;
    logic [6:0] code;
    if (a > 51) return 11'd0;
    s = a / 13;
    r = (a % 13) + 1;
    p = (r > 10) ? 10 : r;
    code = {1'b1, 2'(s), 4'(r)};
    return {code, 4'(p)};
  endfunction

  task automatic pop_check(input string tag);
    logic [10:0] e;
    if (sb_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 1, 0);
    end else begin
      e = sb_q.pop_front();
      chk({tag, "_data_q"}, int'(data_q), int'(e[10:4]));
      chk({tag, "_points_q"}, int'(points_q), int'(e[3:0]));
    end
  endtask

  // drive one address, check comb outputs, then registered copy
  task automatic apply(input int a, input int exp_d, input int exp_p,
                       input string tag);
    @(negedge clk);
    addr = 6'(a);
    #1;
    chk({tag, "_data_out"}, int'(data_out), exp_d);
    chk({tag, "_points"}, int'(points), exp_p);
    sb_q.push_back({7'(exp_d), 4'(exp_p)});
    @(posedge clk);
    #1;
    pop_check(tag);
  endtask

  int da[8] = '{0, 1, 10, 20, 31, 51, 52, 63};
  int dd[8] = '{'h41, 'h42, 'h4B, 'h58, 'h66, 'h7D, 'h00, 'h00};
  int dp[8] = '{1, 2, 10, 8, 6, 10, 0, 0};

  bit seen[128];
  int dups;
  logic [10:0] m;

  initial begin
    checks   = 0;
    failures = 0;
    dups     = 0;
    rst_n    = 1'b0;
    addr     = 6'd20;

    // reset held: registers clear, comb path live
    repeat (2) @(posedge clk);
    #1;
    chk("rst_data_q", int'(data_q), 0);
    chk("rst_points_q", int'(points_q), 0);
    chk("rst_data_out", int'(data_out), 'h58);
    chk("rst_points", int'(points), 8);

    // first edge after release loads lookup
    @(negedge clk);
    rst_n = 1'b1;
    sb_q.push_back({7'h58, 4'd8});
    @(posedge clk);
    #1;
    pop_check("rel");

    // mid-cycle async reset
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_data_q", int'(data_q), 0);
    chk("async_points_q", int'(points_q), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // directed vectors
    for (int i = 0; i < 8; i++) begin
      apply(da[i], dd[i], dp[i], $sformatf("dir%0d", da[i]));
    end

    // mid-cycle address change
    @(negedge clk);
    addr = 6'd5;
    #1;
    addr = 6'd7;
    #1;
    m = ref_card(7);
    chk("mid_data_out", int'(data_out), int'(m[10:4]));
    chk("mid_points", int'(points), int'(m[3:0]));
    sb_q.push_back(m);
    @(posedge clk);
    #1;
    pop_check("mid");

    // exhaustive sweep with uniqueness of valid codes
    for (int a = 0; a < 64; a++) begin
      m = ref_card(a);
      apply(a, int'(m[10:4]), int'(m[3:0]), $sformatf("sw%0d", a));
      if (a < 52) begin
        if (seen[data_out]) dups++;
        seen[data_out] = 1'b1;
      end
    end
    chk("unique_codes_dups", dups, 0);
    chk("sb_drained", sb_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
